cp0_exception_ctrl: RTL and testbench

- Producer side of the coprocessor-0 register file's write interface. It decides when an exception, interrupt or ERET commits.
- Inputs: MEM-stage exception flags, hardware interrupt lines, the timer pulse, and the CP0 forwarded outputs (status, cause, epc, ebase).
- Outputs: registered write strobes and data for badaddr/status/cause/epc, a pipeline flush, and a PC redirect.

---
 rtl/cp0_defs_pkg.sv | 51 +++++
 rtl/cp0_int_sync.sv | 64 ++++++
 rtl/cp0_exception_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs_pkg.sv
// Shared definitions for the CP0 exception controller: exception codes,
// CP0 register bit positions, the exception vector offset and FSM encoding.
package cp0_defs;

    // ExcCode values written into Cause[6:2]
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status register fields
    localparam int unsigned ST_IE_BIT  = 0;
    localparam int unsigned ST_EXL_BIT = 1;
    localparam int unsigned ST_IM_HI   = 15;
    localparam int unsigned ST_IM_LO   = 8;

    // Cause register fields
    localparam int unsigned CA_IP_HI   = 15;
    localparam int unsigned CA_IP_LO   = 8;
    localparam int unsigned CA_HWIP_LO = 10;
    localparam int unsigned CA_BD_BIT  = 31;
    localparam int unsigned CA_CODE_HI = 6;
    localparam int unsigned CA_CODE_LO = 2;

    // General exception vector offset from EBase
    localparam logic [11:0] EXC_VEC_OFFSET = 12'h180;

    // Status.EXL as a 32-bit mask
    localparam logic [31:0] EXL_MASK = 32'h0000_0002;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_COMMIT = 2'd1,
        FSM_FLUSH  = 2'd2
    } fsm_state_t;

    // Address-related exceptions also report the faulting address in BadVAddr
    function automatic logic loads_badaddr(input logic [4:0] code);
        case (code)
            EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES: loads_badaddr = 1'b1;
            default:                                         loads_badaddr = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Hardware interrupt synchroniser and timer-interrupt latch.
// hwIntSync[5] (IP7) is the synchronised line OR the latched timer pulse.
module cp0_int_sync
    import cp0_defs::*;
#(
    parameter bit HW_INT_SYNC = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ready,
    input  logic [5:0] hwInt,
    input  logic       clockInterrupt,
    input  logic       compareWrite,
    output logic [5:0] hwIntSync
);

    logic [5:0] line_s;
    logic       timer_r;

    generate
        if (HW_INT_SYNC) begin : g_sync
            logic [5:0] sync1_r;
            logic [5:0] sync2_r;

            // Two-flop synchroniser on the external interrupt lines
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_r <= 6'd0;
                    sync2_r <= 6'd0;
                end else if (ready) begin
                    sync1_r <= hwInt;
                    sync2_r <= sync1_r;
                end else begin
                    sync1_r <= sync1_r;
                    sync2_r <= sync2_r;
                end
            end

            assign line_s = sync2_r;
        end else begin : g_direct
            assign line_s = hwInt;
        end
    endgenerate

    // Timer latch: a pulse sets it, a compare write clears it, set wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_r <= 1'b0;
        end else if (ready) begin
            if (clockInterrupt) begin
                timer_r <= 1'b1;
            end else if (compareWrite) begin
                timer_r <= 1'b0;
            end else begin
                timer_r <= timer_r;
            end
        end else begin
            timer_r <= timer_r;
        end
    end

    assign hwIntSync = {line_s[5] | timer_r, line_s[4:0]};

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception/interrupt/ERET commit controller. Detects events in the MEM
// stage, produces one registered commit cycle of CP0 writes plus a redirect,
// then holds the pipeline flush for FLUSH_CYCLES further cycles.
module cp0_exception_ctrl
    import cp0_defs::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter bit HW_INT_SYNC  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic        memValid,
    input  logic [31:0] memPc,
    input  logic        memDelaySlot,
    input  logic        excFetchAddr,
    input  logic        excFetchTlb,
    input  logic        excReserved,
    input  logic        excSyscall,
    input  logic        excBreak,
    input  logic        excOverflow,
    input  logic        excLoadAddr,
    input  logic        excStoreAddr,
    input  logic        excTlbLoad,
    input  logic        excTlbStore,
    input  logic        excTlbMod,
    input  logic [31:0] badAddr,
    input  logic        isEret,
    input  logic [5:0]  hwInt,
    input  logic        clockInterrupt,
    input  logic        compareWrite,
    input  logic [31:0] status12Out,
    input  logic [31:0] cause13Out,
    input  logic [31:0] epc14Out,
    input  logic [31:0] ebase15Out,
    output logic        write8,
    output logic        write12,
    output logic        write13,
    output logic        write14,
    output logic [31:0] write8data,
    output logic [31:0] write12data,
    output logic [31:0] write13data,
    output logic [31:0] write14data,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirectPc,
    output logic        excBusy
);

    // FLUSH state lasts FLUSH_CYCLES cycles: counter loads FLUSH_CYCLES-1
    localparam int               CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fsm_state_t       state_r;
    fsm_state_t       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    logic [5:0]  ip_pend_s;
    logic [7:0]  ip_vec_s;
    logic        irq_s;
    logic        exc_hit_s;
    logic [4:0]  exc_code_s;
    logic        fetch_fault_s;
    logic        eret_s;
    logic        take_exc_s;
    logic        take_eret_s;
    logic [31:0] cause_new_s;
    logic [31:0] epc_new_s;
    logic        unused_ebase_s;

    logic        write8_r, write12_r, write13_r, write14_r;
    logic [31:0] write8data_r, write12data_r, write13data_r, write14data_r;
    logic        flush_r, redirect_r, busy_r;
    logic [31:0] redirect_pc_r;

    cp0_int_sync #(
        .HW_INT_SYNC(HW_INT_SYNC)
    ) u_int_sync (
        .clock         (clock),
        .reset         (reset),
        .ready         (ready),
        .hwInt         (hwInt),
        .clockInterrupt(clockInterrupt),
        .compareWrite  (compareWrite),
        .hwIntSync     (ip_pend_s)
    );

    assign ip_vec_s = {ip_pend_s, cause13Out[CA_IP_LO+1:CA_IP_LO]};
    assign irq_s    = memValid & status12Out[ST_IE_BIT] & ~status12Out[ST_EXL_BIT]
                    & (|(ip_vec_s & status12Out[ST_IM_HI:ST_IM_LO]));

    // Priority encoder: interrupt first, then the exception flags in order
    always_comb begin
        exc_hit_s     = 1'b1;
        exc_code_s    = EXC_INT;
        fetch_fault_s = 1'b0;
        if (!memValid) begin
            exc_hit_s = 1'b0;
        end else if (irq_s) begin
            exc_code_s = EXC_INT;
        end else if (excFetchAddr) begin
            exc_code_s    = EXC_ADEL;
            fetch_fault_s = 1'b1;
        end else if (excFetchTlb) begin
            exc_code_s    = EXC_TLBL;
            fetch_fault_s = 1'b1;
        end else if (excReserved) begin
            exc_code_s = EXC_RI;
        end else if (excSyscall) begin
            exc_code_s = EXC_SYS;
        end else if (excBreak) begin
            exc_code_s = EXC_BP;
        end else if (excOverflow) begin
            exc_code_s = EXC_OV;
        end else if (excLoadAddr) begin
            exc_code_s = EXC_ADEL;
        end else if (excStoreAddr) begin
            exc_code_s = EXC_ADES;
        end else if (excTlbLoad) begin
            exc_code_s = EXC_TLBL;
        end else if (excTlbStore) begin
            exc_code_s = EXC_TLBS;
        end else if (excTlbMod) begin
            exc_code_s = EXC_MOD;
        end else begin
            exc_hit_s = 1'b0;
        end
    end

    assign eret_s = memValid & isEret & ~exc_hit_s;

    // New Cause value: BD, pending hardware IP and ExcCode replaced
    always_comb begin
        cause_new_s                         = cause13Out;
        cause_new_s[CA_BD_BIT]              = memDelaySlot;
        cause_new_s[CA_IP_HI:CA_HWIP_LO]    = ip_pend_s;
        cause_new_s[CA_CODE_HI:CA_CODE_LO]  = exc_code_s;
    end

    assign epc_new_s      = memDelaySlot ? (memPc - 32'd4) : memPc;
    assign unused_ebase_s = ^ebase15Out[11:0];

    // Next-state logic: IDLE -> COMMIT (one cycle) -> FLUSH (counted) -> IDLE
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        take_exc_s   = 1'b0;
        take_eret_s  = 1'b0;
        case (state_r)
            FSM_IDLE: begin
                if (exc_hit_s) begin
                    take_exc_s   = 1'b1;
                    state_next_s = FSM_COMMIT;
                end else if (eret_s) begin
                    take_eret_s  = 1'b1;
                    state_next_s = FSM_COMMIT;
                end else begin
                    state_next_s = FSM_IDLE;
                end
            end
            FSM_COMMIT: begin
                state_next_s = FSM_FLUSH;
                cnt_next_s   = CNT_LOAD;
            end
            FSM_FLUSH: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = FSM_IDLE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = FSM_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State and flush counter, frozen while ready is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= FSM_IDLE;
            cnt_r   <= CNT_ZERO;
        end else if (ready) begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered commit outputs: strobes for one cycle, data held between commits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write8_r      <= 1'b0;
            write12_r     <= 1'b0;
            write13_r     <= 1'b0;
            write14_r     <= 1'b0;
            write8data_r  <= 32'd0;
            write12data_r <= 32'd0;
            write13data_r <= 32'd0;
            write14data_r <= 32'd0;
            flush_r       <= 1'b0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            busy_r        <= 1'b0;
        end else if (ready) begin
            write8_r   <= take_exc_s & loads_badaddr(exc_code_s);
            write12_r  <= take_exc_s | take_eret_s;
            write13_r  <= take_exc_s;
            write14_r  <= take_exc_s;
            redirect_r <= take_exc_s | take_eret_s;
            flush_r    <= (state_next_s != FSM_IDLE);
            busy_r     <= (state_next_s != FSM_IDLE);
            if (take_exc_s) begin
                write12data_r <= status12Out | EXL_MASK;
                write13data_r <= cause_new_s;
                write14data_r <= epc_new_s;
                redirect_pc_r <= {ebase15Out[31:12], EXC_VEC_OFFSET};
                if (loads_badaddr(exc_code_s)) begin
                    write8data_r <= fetch_fault_s ? memPc : badAddr;
                end else begin
                    write8data_r <= write8data_r;
                end
            end else if (take_eret_s) begin
                write12data_r <= status12Out & ~EXL_MASK;
                redirect_pc_r <= epc14Out;
            end else begin
                write12data_r <= write12data_r;
                redirect_pc_r <= redirect_pc_r;
            end
        end else begin
            write8_r   <= write8_r;
            write12_r  <= write12_r;
            write13_r  <= write13_r;
            write14_r  <= write14_r;
            redirect_r <= redirect_r;
            flush_r    <= flush_r;
            busy_r     <= busy_r;
        end
    end

    assign write8      = write8_r;
    assign write12     = write12_r;
    assign write13     = write13_r;
    assign write14     = write14_r;
    assign write8data  = write8data_r;
    assign write12data = write12data_r;
    assign write13data = write13data_r;
    assign write14data = write14data_r;
    assign flush       = flush_r;
    assign redirect    = redirect_r;
    assign redirectPc  = redirect_pc_r;
    assign excBusy     = busy_r;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_cp0_exception_ctrl;

    localparam int FC = 2;

    logic        clock, reset, ready, memValid, memDelaySlot, isEret;
    logic [31:0] memPc, badAddr, status12Out, cause13Out, epc14Out, ebase15Out;
    logic        excFetchAddr, excFetchTlb, excReserved, excSyscall, excBreak, excOverflow;
    logic        excLoadAddr, excStoreAddr, excTlbLoad, excTlbStore, excTlbMod;
    logic [5:0]  hwInt;
    logic        clockInterrupt, compareWrite;
    logic        write8, write12, write13, write14, flush, redirect, excBusy;
    logic [31:0] write8data, write12data, write13data, write14data, redirectPc;

    cp0_exception_ctrl #(.FLUSH_CYCLES(FC), .HW_INT_SYNC(1'b1)) dut (
        .clock(clock), .reset(reset), .ready(ready), .memValid(memValid), .memPc(memPc),
        .memDelaySlot(memDelaySlot), .excFetchAddr(excFetchAddr), .excFetchTlb(excFetchTlb),
        .excReserved(excReserved), .excSyscall(excSyscall), .excBreak(excBreak),
        .excOverflow(excOverflow), .excLoadAddr(excLoadAddr), .excStoreAddr(excStoreAddr),
        .excTlbLoad(excTlbLoad), .excTlbStore(excTlbStore), .excTlbMod(excTlbMod),
        .badAddr(badAddr), .isEret(isEret), .hwInt(hwInt), .clockInterrupt(clockInterrupt),
        .compareWrite(compareWrite), .status12Out(status12Out), .cause13Out(cause13Out),
        .epc14Out(epc14Out), .ebase15Out(ebase15Out), .write8(write8), .write12(write12),
        .write13(write13), .write14(write14), .write8data(write8data), .write12data(write12data),
        .write13data(write13data), .write14data(write14data), .flush(flush), .redirect(redirect),
        .redirectPc(redirectPc), .excBusy(excBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_busy;           // cycles of flush still to come (0 = idle)
    logic [5:0]  m_h1, m_h2;       // hwInt one and two ready-cycles ago
    logic        m_latch;
    logic        e_w8, e_w12, e_w13, e_w14, e_redir, e_flush;
    logic [31:0] e_d8, e_d12, e_d13, e_d14, e_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [4:0] code_of(input int idx);
        case (idx)
            0: code_of = 5'd4;   1: code_of = 5'd2;   2: code_of = 5'd10;
            3: code_of = 5'd8;   4: code_of = 5'd9;   5: code_of = 5'd12;
            6: code_of = 5'd4;   7: code_of = 5'd5;   8: code_of = 5'd2;
            9: code_of = 5'd3;   default: code_of = 5'd1;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_h1 = 6'd0; m_h2 = 6'd0; m_latch = 1'b0;
        e_w8 = 1'b0; e_w12 = 1'b0; e_w13 = 1'b0; e_w14 = 1'b0; e_redir = 1'b0; e_flush = 1'b0;
        e_d8 = 32'd0; e_d12 = 32'd0; e_d13 = 32'd0; e_d14 = 32'd0; e_rpc = 32'd0;
    endtask

    // Predict outputs after the coming clock edge from the current inputs
    task automatic model_edge();
        logic [5:0]  ip6;
        logic [7:0]  ipv;
        logic        irq;
        logic [10:0] f;
        int          hit;
        logic [4:0]  code;
        logic [31:0] c;
        if (!ready) return;
        ip6 = {m_h2[5] | m_latch, m_h2[4:0]};
        e_w8 = 1'b0; e_w12 = 1'b0; e_w13 = 1'b0; e_w14 = 1'b0; e_redir = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            ipv = {ip6, cause13Out[9:8]};
            irq = memValid && status12Out[0] && !status12Out[1] && ((ipv & status12Out[15:8]) != 8'd0);
            f = {excTlbMod, excTlbStore, excTlbLoad, excStoreAddr, excLoadAddr, excOverflow,
                 excBreak, excSyscall, excReserved, excFetchTlb, excFetchAddr};
            hit = -1;
            if (memValid) for (int i = 0; i < 11; i++) if (f[i] && hit < 0) hit = i;
            if (irq || hit >= 0) begin
                code = irq ? 5'd0 : code_of(hit);
                e_w12 = 1'b1; e_w13 = 1'b1; e_w14 = 1'b1; e_redir = 1'b1;
                e_d14 = memPc - (memDelaySlot ? 32'd4 : 32'd0);
                c = cause13Out; c[31] = memDelaySlot; c[15:10] = ip6; c[6:2] = code;
                e_d13 = c;
                e_d12 = status12Out | 32'd2;
                e_rpc = {ebase15Out[31:12], 12'h180};
                if (code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) begin
                    e_w8 = 1'b1;
                    e_d8 = (!irq && hit < 2) ? memPc : badAddr;
                end
                m_busy = FC + 1;
            end else if (memValid && isEret) begin
                e_w12 = 1'b1; e_redir = 1'b1;
                e_d12 = status12Out & ~32'd2;
                e_rpc = epc14Out;
                m_busy = FC + 1;
            end
        end
        e_flush = (m_busy > 0);
        m_latch = clockInterrupt ? 1'b1 : (compareWrite ? 1'b0 : m_latch);
        m_h2 = m_h1;
        m_h1 = hwInt;
    endtask

    task automatic compare_all();
        chk("write8",   {31'd0, write8},   {31'd0, e_w8});
        chk("write12",  {31'd0, write12},  {31'd0, e_w12});
        chk("write13",  {31'd0, write13},  {31'd0, e_w13});
        chk("write14",  {31'd0, write14},  {31'd0, e_w14});
        chk("redirect", {31'd0, redirect}, {31'd0, e_redir});
        chk("flush",    {31'd0, flush},    {31'd0, e_flush});
        chk("excBusy",  {31'd0, excBusy},  {31'd0, e_flush});
        if (e_w8)    chk("write8data",  write8data,  e_d8);
        if (e_w12)   chk("write12data", write12data, e_d12);
        if (e_w13)   chk("write13data", write13data, e_d13);
        if (e_w14)   chk("write14data", write14data, e_d14);
        if (e_redir) chk("redirectPc",  redirectPc,  e_rpc);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        memValid = 1'b0; isEret = 1'b0; memDelaySlot = 1'b0;
        excFetchAddr = 1'b0; excFetchTlb = 1'b0; excReserved = 1'b0; excSyscall = 1'b0;
        excBreak = 1'b0; excOverflow = 1'b0; excLoadAddr = 1'b0; excStoreAddr = 1'b0;
        excTlbLoad = 1'b0; excTlbStore = 1'b0; excTlbMod = 1'b0;
        clockInterrupt = 1'b0; compareWrite = 1'b0;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < FC + 2; i++) step();
    endtask

    int nfl;

    initial begin
        reset = 1'b1; ready = 1'b1; quiet();
        memPc = 32'd0; badAddr = 32'd0; hwInt = 6'd0;
        status12Out = 32'd0; cause13Out = 32'd0; epc14Out = 32'd0; ebase15Out = 32'h8000_0000;
        model_reset();
        #12;
        compare_all();
        chk("rst_w8data",  write8data,  32'd0);
        chk("rst_w12data", write12data, 32'd0);
        chk("rst_w13data", write13data, 32'd0);
        chk("rst_w14data", write14data, 32'd0);
        chk("rst_rpc",     redirectPc,  32'd0);
        reset = 1'b0;
        step(); step();

        // Syscall, not in a delay slot
        memValid = 1'b1; memPc = 32'h8000_1000; excSyscall = 1'b1;
        step();
        chk("sys_epc",  write14data, 32'h8000_1000);
        chk("sys_code", {27'd0, write13data[6:2]}, 32'd8);
        chk("sys_exl",  {31'd0, write12data[1]}, 32'd1);
        chk("sys_vec",  redirectPc, 32'h8000_0180);
        nfl = int'(flush);
        quiet();
        for (int i = 0; i < 3; i++) begin step(); nfl += int'(flush); end
        chk("sys_flush_len", nfl, 32'd3);
        step();

        // Overflow in a delay slot
        memValid = 1'b1; memPc = 32'h8000_2004; memDelaySlot = 1'b1; excOverflow = 1'b1;
        step();
        chk("ov_epc",  write14data, 32'h8000_2000);
        chk("ov_bd",   {31'd0, write13data[31]}, 32'd1);
        chk("ov_code", {27'd0, write13data[6:2]}, 32'd12);
        drain();

        // Store address fault together with overflow, then alone
        memValid = 1'b1; memPc = 32'h8000_3000; badAddr = 32'h0000_0003;
        excStoreAddr = 1'b1; excOverflow = 1'b1;
        step();
        chk("ovst_code", {27'd0, write13data[6:2]}, 32'd12);
        chk("ovst_w8",   {31'd0, write8}, 32'd0);
        drain();
        memValid = 1'b1; excStoreAddr = 1'b1;
        step();
        chk("ades_code", {27'd0, write13data[6:2]}, 32'd5);
        chk("ades_w8",   {31'd0, write8}, 32'd1);
        chk("ades_bad",  write8data, 32'h0000_0003);
        drain();

        // Timer interrupt
        clockInterrupt = 1'b1; step();
        clockInterrupt = 1'b0; memValid = 1'b1; status12Out = 32'h0000_8001;
        step();
        chk("irq_code", {27'd0, write13data[6:2]}, 32'd0);
        chk("irq_ip7",  {31'd0, write13data[15]}, 32'd1);
        drain();
        // EXL set: no commit, latch held
        memValid = 1'b1; status12Out = 32'h0000_8003; clockInterrupt = 1'b1;
        step();
        clockInterrupt = 1'b0;
        step(); step();
        chk("exl_noflush", {31'd0, flush}, 32'd0);
        status12Out = 32'h0000_8001;
        step();
        chk("latch_held", {31'd0, write13}, 32'd1);
        drain();
        compareWrite = 1'b1; step();
        compareWrite = 1'b0; memValid = 1'b1;
        step(); step();
        chk("latch_clr", {31'd0, flush}, 32'd0);
        quiet(); step();

        // ERET
        memValid = 1'b1; isEret = 1'b1; status12Out = 32'h0000_0003; epc14Out = 32'h8000_3000;
        step();
        chk("eret_st",  write12data, 32'h0000_0001);
        chk("eret_pc",  redirectPc,  32'h8000_3000);
        chk("eret_w13", {31'd0, write13}, 32'd0);
        chk("eret_w14", {31'd0, write14}, 32'd0);
        drain();

        // ready low during FLUSH
        status12Out = 32'd0;
        memValid = 1'b1; excBreak = 1'b1;
        step();
        quiet(); step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("stall_flush", {31'd0, flush}, 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset mid-FLUSH
        memValid = 1'b1; excReserved = 1'b1;
        step();
        quiet(); step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_flush", {31'd0, flush},   32'd0);
        chk("arst_busy",  {31'd0, excBusy}, 32'd0);
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        step();

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            ready        = ($urandom_range(0, 9) != 0);
            memValid     = ($urandom_range(0, 3) != 0);
            memPc        = $urandom & 32'hFFFF_FFFC;
            memDelaySlot = $urandom_range(0, 1) == 1;
            badAddr      = $urandom;
            excFetchAddr = ($urandom_range(0, 24) == 0);
            excFetchTlb  = ($urandom_range(0, 24) == 0);
            excReserved  = ($urandom_range(0, 24) == 0);
            excSyscall   = ($urandom_range(0, 24) == 0);
            excBreak     = ($urandom_range(0, 24) == 0);
            excOverflow  = ($urandom_range(0, 24) == 0);
            excLoadAddr  = ($urandom_range(0, 24) == 0);
            excStoreAddr = ($urandom_range(0, 24) == 0);
            excTlbLoad   = ($urandom_range(0, 24) == 0);
            excTlbStore  = ($urandom_range(0, 24) == 0);
            excTlbMod    = ($urandom_range(0, 24) == 0);
            isEret       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) hwInt = 6'($urandom);
            clockInterrupt = ($urandom_range(0, 9) == 0);
            compareWrite   = ($urandom_range(0, 9) == 0);
            status12Out    = $urandom;
            if ($urandom_range(0, 1) == 1) status12Out[1:0] = 2'b01;
            cause13Out = $urandom;
            epc14Out   = $urandom;
            ebase15Out = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
